// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo-N counter family: FSM state codes,
// direction constants and a ceiling-log2 helper for sizing counters.
package mod_counter_pkg;

  // Legacy-compatible state constants for the counter FSM
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2; returns 0 for values 0 and 1
  function automatic int clog2(input longint unsigned value);
    longint unsigned v;
    int r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Combinational next-value and wrap-flag logic for a modulo-MODULUS counter.
// The wrap point is always compared against MODULUS-1 so the result never
// depends on natural 2**WIDTH overflow.
module mod_counter_step
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 200
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  // Next count in the requested direction, flagging the wrap step
  always_comb begin
    o_next = i_count;
    o_wrap = 1'b0;
    if (i_up_dn == DIR_UP) begin
      if (i_count >= MAX_CNT) begin
        o_next = '0;
        o_wrap = 1'b1;
      end else begin
        o_next = i_count + 1'b1;
      end
    end else if (i_up_dn == DIR_DOWN) begin
      if (i_count == '0) begin
        o_next = MAX_CNT;
        o_wrap = 1'b1;
      end else begin
        o_next = i_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter_gen.sv
// Parametrised modulo-N counter with up/down, parallel load, start/stop and
// one-shot mode. Optional step prescaler enabled by MOD_COUNTER_PRESCALE_EN.
// Per-cycle priority: load > stop > start > step.
module mod_counter_gen
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 200,
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter_gen: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter_gen: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter_gen: PRESCALE must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [1:0]       r_state;
  logic             r_oneshot;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;

  assign w_load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  mod_counter_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .i_count (r_count),
    .i_up_dn (up_dn),
    .o_next  (w_next),
    .o_wrap  (w_wrap)
  );

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_active;
  logic          w_pre_clear;

  assign w_active    = (r_state == ST_RUN) && en;
  assign w_pre_clear = load || stop || (start && (r_state != ST_RUN));
  assign w_step      = w_active && !w_pre_clear && (r_pre == PRE_LAST);

  // Prescaler: counts enabled RUN cycles, cleared by load/stop/start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_pre_clear) begin
      r_pre <= '0;
    end else if (w_active) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
    end
  end
`else
  assign w_step = (r_state == ST_RUN) && en;
`endif

  // Counter FSM: load/stop/start control plus stepping and wrap handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_tc      <= 1'b0;
      r_state   <= ST_IDLE;
      r_oneshot <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count <= w_load_clamped;
        r_state <= ST_IDLE;
      end else if (stop) begin
        r_state <= ST_IDLE;
      end else if (start && (r_state != ST_RUN)) begin
        r_state   <= ST_RUN;
        r_oneshot <= oneshot;
      end else if (w_step) begin
        r_count <= w_next;
        if (w_wrap) begin
          r_tc <= 1'b1;
          if (r_oneshot) r_state <= ST_DONE;
        end
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_mod_counter_gen.sv
// Self-checking bench for mod_counter_gen: directed table, hand sequences
// for multi-cycle corners, and randomized traffic against a behavioural model.
module tb_mod_counter_gen;

  localparam int W  = 8;
  localparam int MI = 200;
  localparam int P  = 4;
`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PT = P;
`else
  localparam int PT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, en, up_dn, oneshot, start, stop, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, busy, done;

  mod_counter_gen #(
    .WIDTH    (W),
    .MODULUS  (MI),
    .PRESCALE (P)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .oneshot  (oneshot),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: running/done flags, integer count, enabled-cycle tally
  int m_count;
  bit m_run, m_done, m_os, m_tc;
  int m_pre;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_run = 0; m_done = 0; m_os = 0; m_tc = 0; m_pre = 0;
  endtask

  task automatic model_step();
    bit wrapped;
    m_tc = 0;
    if (load) begin
      m_count = (int'(load_val) > MI - 1) ? MI - 1 : int'(load_val);
      m_run = 0; m_done = 0; m_pre = 0;
    end else if (stop) begin
      m_run = 0; m_done = 0; m_pre = 0;
    end else if (start && !m_run) begin
      m_run = 1; m_done = 0; m_os = oneshot; m_pre = 0;
    end else if (m_run && en) begin
      m_pre++;
      if (m_pre == PT) begin
        m_pre = 0;
        wrapped = up_dn ? (m_count == MI - 1) : (m_count == 0);
        m_count = up_dn ? (m_count + 1) % MI : (m_count + MI - 1) % MI;
        if (wrapped) begin
          m_tc = 1;
          if (m_os) begin m_run = 0; m_done = 1; end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".count"}, int'(count), m_count);
    chk({tag, ".tc"},    int'(tc),    int'(m_tc));
    chk({tag, ".busy"},  int'(busy),  int'(m_run));
    chk({tag, ".done"},  int'(done),  int'(m_done));
  endtask

  task automatic idle_inputs();
    en = 0; up_dn = 1; oneshot = 0; start = 0; stop = 0; load = 0; load_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    logic ld, sp, st, e, ud, os;
    int   lv;
    int   reps;
    int   c;
    logic b, d, t;
  } vec_t;

  vec_t tbl[21];
  int   tc_seen;

  initial begin
    //          ld sp st e  ud os  lv  reps  cnt  b  d  t
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 250, 1,  199, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 1, 0, 250, 1,  199, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 1, 0,   0, 1,  199, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 1, 0,   0, 1,  199, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 0,   0, PT,   0, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 1, 0,   0, PT,   1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0,   0, 3,    1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 0,   0, PT,   0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 0,   0, PT, 199, 1, 0, 1};
    tbl[9]  = '{0, 0, 1, 1, 0, 0,   0, PT, 198, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 0,   0, 1,  198, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 195, 1,  195, 0, 0, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 1,   0, 1,  195, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 1, 0,   0, PT, 196, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 1, 0,   0, PT, 197, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 1, 1, 0,   0, PT, 198, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 1, 0,   0, PT, 199, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 1, 0,   0, PT,   0, 0, 1, 1};
    tbl[18] = '{0, 0, 0, 1, 1, 0,   0, PT,   0, 0, 1, 0};
    tbl[19] = '{0, 0, 1, 0, 1, 0,   0, 1,    0, 1, 0, 0};
    tbl[20] = '{1, 0, 0, 1, 1, 0,   7, 1,    7, 0, 0, 0};

    do_reset();
    chk("reset.count", int'(count), 0);
    chk("reset.busy",  int'(busy),  0);
    chk("reset.done",  int'(done),  0);
    chk("reset.tc",    int'(tc),    0);

    // Directed table
    for (int i = 0; i < 21; i++) begin
      load = tbl[i].ld; stop = tbl[i].sp; start = tbl[i].st;
      en = tbl[i].e; up_dn = tbl[i].ud; oneshot = tbl[i].os;
      load_val = W'(tbl[i].lv);
      for (int r = 0; r < tbl[i].reps; r++) tick();
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].c);
      chk($sformatf("tbl%0d.busy", i),  int'(busy),  int'(tbl[i].b));
      chk($sformatf("tbl%0d.done", i),  int'(done),  int'(tbl[i].d));
      chk($sformatf("tbl%0d.tc", i),    int'(tc),    int'(tbl[i].t));
    end

    // Asynchronous reset mid-run at count 57
    do_reset();
    start = 1; up_dn = 1; tick(); start = 0; en = 1;
    for (int i = 0; i < 2000 && count != 57; i++) tick();
    chk("mid.reach57", int'(count), 57);
    #2 reset = 1;
    #1;
    chk("mid.count", int'(count), 0);
    chk("mid.busy",  int'(busy),  0);
    chk("mid.done",  int'(done),  0);
    chk("mid.tc",    int'(tc),    0);
    @(posedge clk); #1;
    reset = 0; idle_inputs(); model_reset();

    // Continuous up: 600 steps produce exactly 3 tc pulses
    start = 1; tick(); start = 0; en = 1; up_dn = 1;
    tc_seen = 0;
    for (int i = 0; i < 600 * PT; i++) begin
      tick();
      if (tc) tc_seen++;
    end
    chk("cont.tc_pulses", tc_seen, 3);
    chk("cont.count", int'(count), 0);

    // Down wrap from 0
    en = 0; load = 1; load_val = 0; tick(); load = 0;
    up_dn = 0; start = 1; tick(); start = 0; en = 1;
    for (int i = 0; i < PT; i++) tick();
    chk("down.first", int'(count), 199);
    chk("down.tc1",   int'(tc),    1);
    for (int i = 0; i < PT; i++) tick();
    chk("down.second", int'(count), 198);
    chk("down.tc2",    int'(tc),    0);

    // One-shot holds at 0 after completion
    en = 0; load = 1; load_val = 198; tick(); load = 0;
    up_dn = 1; oneshot = 1; start = 1; tick(); start = 0; oneshot = 0; en = 1;
    for (int i = 0; i < 100 && !done; i++) tick();
    chk("os.done", int'(done), 1);
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (count != 0 || !done || busy || tc) tc_seen++;
    end
    chk("os.hold_bad_cycles", tc_seen, 0);
    start = 1; tick(); start = 0;
    chk("os.restart_done", int'(done), 0);
    chk("os.restart_busy", int'(busy), 1);

    // Prescale behaviour: 42 enabled cycles, pause, 2 more
    do_reset();
    up_dn = 1; start = 1; tick(); start = 0; en = 1;
    for (int i = 0; i < 42; i++) tick();
    chk("pre.after42", int'(count), 42 / PT);
    en = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre.hold", int'(count), 42 / PT);
    en = 1;
    for (int i = 0; i < 2; i++) tick();
    chk("pre.after44", int'(count), 44 / PT);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      load     = ($urandom_range(99, 0) < 2);
      stop     = ($urandom_range(99, 0) < 2);
      start    = ($urandom_range(99, 0) < 6);
      en       = ($urandom_range(99, 0) < 85);
      oneshot  = ($urandom_range(99, 0) < 40);
      load_val = W'($urandom_range(255, 0));
      if ($urandom_range(99, 0) < 4) up_dn = ~up_dn;
      tick();
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
